br_reader: RTL and testbench
============================

BR_READER -- requirements
Module: br_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, request a dump; sampled only in IDLE.
REQ-006 SHALL have port first, input, ADDR_W, first register index; latched on accepted start.
REQ-007 SHALL have port last, input, ADDR_W, final register index; latched on accepted start.
REQ-008 SHALL have port br_a1, output, ADDR_W, BR read address 1.
REQ-009 SHALL have port br_a2, output, ADDR_W, BR read address 2.
REQ-010 SHALL have port br_rd1, input, DATA_W, BR asynchronous read data 1.
REQ-011 SHALL have port br_rd2, input, DATA_W, BR asynchronous read data 2.
REQ-012 SHALL have port m_valid, output, 1, stream word valid.
REQ-013 SHALL have port m_ready, input, 1, downstream ready.
REQ-014 SHALL have port m_data, output, DATA_W, register contents.
REQ-015 SHALL have port m_addr, output, ADDR_W, index of m_data.
REQ-016 SHALL have port m_last, output, 1, marks the final word.
REQ-017 SHALL have port busy, output, 1, high from accepted start until done.
REQ-018 SHALL have port done, output, 1, one-cycle pulse at completion.

Function
REQ-019 SHALL implement states IDLE, FETCH, EMIT, DONE: IDLE->FETCH on start; FETCH->EMIT; EMIT->FETCH when buffer drains and words remain; EMIT->DONE on handshake of m_last word; DONE->IDLE unconditionally.
REQ-020 SHALL read count = ((last - first) mod 2^ADDR_W) + 1 words; first > last wraps through 31 to 0; first == last yields exactly 1 word.
REQ-021 SHALL, per fetch, drive br_a1 = ptr and br_a2 = ptr+1 (mod 32), capturing both into a 2-entry buffer, or only br_rd1 when 1 word remains.
REQ-022 SHALL permit refill in the same cycle the last buffered entry is popped, sustaining 1 word/cycle with m_ready held high.
REQ-023 SHALL give latency: start high in cycle 0, FETCH addresses driven in cycle 1, m_valid high with word first in cycle 2.
REQ-024 SHALL transfer a word only when m_valid && m_ready; m_data, m_addr, m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 SHALL drive words in ascending (wrapping) index order, m_addr exact.
REQ-026 SHALL assert done for exactly the cycle in DONE; busy low in that cycle.
REQ-027 SHALL ignore start when not IDLE; first/last changes after acceptance SHALL have no effect.
REQ-028 SHALL drive br_a1 = br_a2 = 0 outside FETCH-capture cycles.
REQ-029 SHALL register all outputs except br_a1/br_a2.

Reset
REQ-030 SHALL, on clock edge with rst_n low, force state IDLE, buffer empty, m_valid=0, m_data=0, m_addr=0, m_last=0, busy=0, done=0, br_a1=br_a2=0.
REQ-031 SHALL abort any dump in progress on reset with no further words or done pulse.

Structure
REQ-032 SHALL take ADDR_W, DATA_W, NREG=32 and the state enum from shared package br_pkg.
REQ-033 SHALL place the 2-entry buffer (push-pair, pop-one, count) in sub-module br_reader_buf.

Verification
REQ-034 BR preloaded x2=DEADBEEF, x3=00000003; first=2,last=3,m_ready=1 -> m_valid cycles 2-3, words DEADBEEF@2, 00000003@3 m_last, done cycle 4.
REQ-035 first=0,last=31,m_ready=1 -> 32 consecutive words, x0=00000000, m_last at addr 31, done once.
REQ-036 first=30,last=1 -> addresses 30,31,0,1 in order, 4 words, m_last at 1.
REQ-037 first=last=5, m_ready low 3 cycles -> single word held stable 3 cycles, m_last=1, one transfer.
REQ-038 start during busy plus rst_n low mid-dump -> no second dump, outputs zero next edge, no done pulse.

Source files
------------

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared widths and FSM state encoding for the register-bank reader
package br_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } br_state_t;

endpackage

// File: rtl/br_reader_buf.sv
// rtl/br_reader_buf.sv - two-entry word buffer: push one or a pair, pop one at the head
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_two        load in0 (and in1 when push_two); only legal when the
//                         buffer is empty after this cycle's pop
//   in0_*, in1_*          word, index and final-word flag for the two slots
//   pop                   drop the head entry
//   head_*                registered head entry; these drive the stream outputs
//   count                 number of occupied entries (0..2)
module br_reader_buf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              push_two,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic              in0_last,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic              in1_last,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic              head_last,
    output logic [1:0]        count
);

    // Entry 0 is always the head so the stream outputs come straight from flops;
    // entry 1 shifts forward on pop.
    logic              tail_valid;
    logic [DATA_W-1:0] tail_data;
    logic [ADDR_W-1:0] tail_addr;
    logic              tail_last;

    assign count = {1'b0, head_valid} + {1'b0, tail_valid};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_addr  <= '0;
            head_last  <= 1'b0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
            tail_addr  <= '0;
            tail_last  <= 1'b0;
        end else begin
            if (pop) begin
                if (tail_valid) begin
                    head_data  <= tail_data;
                    head_addr  <= tail_addr;
                    head_last  <= tail_last;
                    tail_valid <= 1'b0;
                end else begin
                    head_valid <= 1'b0;
                end
            end
            // A push always lands in an empty buffer (possibly emptied by the
            // pop above), so it overrides the shift.
            if (push) begin
                head_valid <= 1'b1;
                head_data  <= in0_data;
                head_addr  <= in0_addr;
                head_last  <= in0_last;
                tail_valid <= push_two;
                if (push_two) begin
                    tail_data <= in1_data;
                    tail_addr <= in1_addr;
                    tail_last <= in1_last;
                end
            end
        end
    end

endmodule

// File: rtl/br_reader.sv
// rtl/br_reader.sv - dumps a wrapping range of register-bank entries onto a valid/ready stream
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, first, last    request a dump of indices first..last (wrapping)
//   br_a1, br_a2          bank read addresses, zero except in capture cycles
//   br_rd1, br_rd2        asynchronous bank read data
//   m_valid/m_ready       stream handshake; m_data, m_addr, m_last payload
//   busy                  high from accepted start until the done cycle
//   done                  one-cycle completion pulse
module br_reader #(
    parameter int ADDR_W = br_pkg::ADDR_W,
    parameter int DATA_W = br_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] br_a1,
    output logic [ADDR_W-1:0] br_a2,
    input  logic [DATA_W-1:0] br_rd1,
    input  logic [DATA_W-1:0] br_rd2,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    import br_pkg::*;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO = ADDR_W'(2);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_TWO = (ADDR_W+1)'(2);

    br_state_t         state;
    br_state_t         state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;      // words not yet fetched; one wider to hold 2^ADDR_W
    logic [1:0]        count;
    logic              fire;
    logic              refill;
    logic              fetch_en;
    logic              two;

    assign fire = m_valid && m_ready;

    // Refilling in the cycle the last buffered word leaves keeps the stream
    // gap-free; a separate FETCH cycle would insert a bubble every two words.
    assign refill   = (state == EMIT) && fire && (count == 2'd1) && (rem != '0);
    assign fetch_en = (state == FETCH) || refill;
    assign two      = (rem >= REM_TWO);

    assign br_a1 = fetch_en ? ptr : '0;
    assign br_a2 = fetch_en ? (ptr + PTR_ONE) : '0;

    br_reader_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch_en),
        .push_two   (two),
        .in0_data   (br_rd1),
        .in0_addr   (ptr),
        .in0_last   (rem == REM_ONE),
        .in1_data   (br_rd2),
        .in1_addr   (ptr + PTR_ONE),
        .in1_last   (rem == REM_TWO),
        .pop        (fire),
        .head_valid (m_valid),
        .head_data  (m_data),
        .head_addr  (m_addr),
        .head_last  (m_last),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                if (fire && m_last) begin
                    state_nxt = DONE;
                end else if ((count == 2'd0) && (rem != '0)) begin
                    // Buffer ran dry without an in-place refill.
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == FETCH) || (state_nxt == EMIT);
            done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            rem <= '0;
        end else if ((state == IDLE) && start) begin
            ptr <= first;
            rem <= {1'b0, last - first} + REM_ONE;
        end else if (fetch_en) begin
            if (two) begin
                ptr <= ptr + PTR_TWO;
                rem <= rem - REM_TWO;
            end else begin
                ptr <= ptr + PTR_ONE;
                rem <= rem - REM_ONE;
            end
        end
    end

endmodule

// File: tb/tb_br_reader.sv
// tb/tb_br_reader.sv - scoreboard bench for br_reader
module tb_br_reader;

    import br_pkg::*;

    localparam int AW = br_pkg::ADDR_W;
    localparam int DW = br_pkg::DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] br_a1;
    logic [AW-1:0] br_a2;
    logic [DW-1:0] br_rd1;
    logic [DW-1:0] br_rd2;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    br_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .first   (first),
        .last    (last),
        .br_a1   (br_a1),
        .br_a2   (br_a2),
        .br_rd1  (br_rd1),
        .br_rd2  (br_rd2),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_addr  (m_addr),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    logic [DW-1:0] regs [NREG];
    assign br_rd1 = regs[br_a1];
    assign br_rd2 = regs[br_a2];

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = hold low, 1 = hold high, 2 = random backpressure
    int ready_mode = 1;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_fire = 0;
    int            n_done = 0;
    int            n_holds = 0;
    int            rise_cyc = -1;
    int            last_fire_cyc = -1;
    int            done_cyc = -1;
    logic          prev_valid = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_hold) begin
            n_holds++;
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_addr", m_addr, prev_addr);
            check("hold_last", m_last, prev_last);
        end
        if (m_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = m_valid;
        prev_hold  = m_valid && !m_ready;
        prev_data  = m_data;
        prev_addr  = m_addr;
        prev_last  = m_last;
        if (rst_n && !busy) check("bank_addr_idle", {br_a1, br_a2}, 0);
        if (m_valid && m_ready) begin
            n_fire++;
            last_fire_cyc = cyc;
            if (sb.size() == 0) begin
                check("extra_word", m_valid, 0);
            end else begin
                e = sb.pop_front();
                check("word_data", m_data, e.data);
                check("word_addr", m_addr, e.addr);
                check("word_last", m_last, e.last);
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            check("busy_at_done", busy, 0);
            check("sb_empty_at_done", sb.size(), 0);
        end
    end

    task automatic push_expected(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        int n;
        span = l - f;
        n = int'(span) + 1;
        for (int k = 0; k < n; k++) begin
            a = f + AW'(k);
            sb.push_back('{data: regs[a], addr: a, last: (k == n - 1)});
        end
    endtask

    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int stall, output int c0);
        logic [AW-1:0] span;
        int n;
        int base_fire;
        int base_done;
        span = l - f;
        n = int'(span) + 1;
        base_fire = n_fire;
        base_done = n_done;
        push_expected(f, l);
        @(posedge clk);
        #1;
        start = 1'b1;
        first = f;
        last  = l;
        c0    = cyc;
        if (stall > 0) ready_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = AW'($urandom);
        last  = AW'($urandom);
        if (stall > 0) begin
            for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
            check("stall_valid_seen", m_valid, 1);
            repeat (stall) @(posedge clk);
            #1;
            ready_mode = 1;
        end
        for (int t = 0; t < 600 && n_done == base_done; t++) @(negedge clk);
        @(negedge clk);
        check("done_once", n_done - base_done, 1);
        check("word_count", n_fire - base_fire, n);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int c0;
        int hb;
        int fb;
        int db;
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int c0;
        int hb;
        int fb;
        int db;
        rst_n = 1'b0;
        start = 1'b0;
        first = '0;
        last  = '0;
        for (int i = 0; i < NREG; i++) regs[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_0107;
        regs[0] = 32'h0000_0000;
        regs[2] = 32'hDEAD_BEEF;
        regs[3] = 32'h0000_0003;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_br_a1", br_a1, 0);
        check("rst_br_a2", br_a2, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // two words, exact latency
        run_dump(5'd2, 5'd3, 0, c0);
        check("lat_first_valid", rise_cyc - c0, 2);
        check("lat_last_fire", last_fire_cyc - c0, 3);
        check("lat_done", done_cyc - c0, 4);

        // full bank, back-to-back
        run_dump(5'd0, 5'd31, 0, c0);
        check("full_no_bubble", last_fire_cyc - rise_cyc, 31);
        check("full_done_cycle", done_cyc - c0, 34);

        // wrap through 31 -> 0
        run_dump(5'd30, 5'd1, 0, c0);
        check("wrap_done_cycle", done_cyc - c0, 6);

        // single word held under backpressure
        hb = n_holds;
        run_dump(5'd5, 5'd5, 3, c0);
        check("single_holds", n_holds - hb, 3);
        check("single_fire_cycle", last_fire_cyc - c0, 5);

        // random backpressure across refills
        ready_mode = 2;
        run_dump(5'd28, 5'd3, 0, c0);
        run_dump(5'd10, 5'd17, 0, c0);
        ready_mode = 1;

        // start while busy is ignored, then reset mid-dump
        db = n_done;
        push_expected(5'd0, 5'd31);
        @(posedge clk);
        #1;
        start = 1'b1;
        first = 5'd0;
        last  = 5'd31;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        first = 5'd9;
        last  = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        fb = n_fire;
        @(negedge clk);
        check("abort_m_valid", m_valid, 0);
        check("abort_m_data", m_data, 0);
        check("abort_m_addr", m_addr, 0);
        check("abort_m_last", m_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_br_a1", br_a1, 0);
        check("abort_br_a2", br_a2, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", n_done - db, 0);
        check("abort_no_words", n_fire - fb, 0);

        // recovery after abort
        run_dump(5'd7, 5'd7, 0, c0);
        check("recover_done_cycle", done_cyc - c0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
